// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the FIFO write port among NUM_REQ w_clk-domain requesters.
// Optional statistics counters (xfer_cnt, stall_cnt) are built when WR_ARB_STATS_EN is defined.
module fifo_wr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_SIZE = 8,
  parameter int MAX_BURST = 4,
  parameter int CNT_SIZE  = 16,
  localparam int IDX_W    = $clog2(NUM_REQ),
  localparam int BC_W     = $clog2(MAX_BURST + 1)
) (
  input  logic                           w_clk,
  input  logic                           wrst_n,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*DATA_SIZE-1:0]   req_data,
  input  logic                           w_full,
  output logic [NUM_REQ-1:0]             gnt,
  output logic                           w_en,
  output logic [DATA_SIZE-1:0]           w_data,
  output logic                           busy,
`ifdef WR_ARB_STATS_EN
  output logic [CNT_SIZE-1:0]            xfer_cnt,
  output logic [CNT_SIZE-1:0]            stall_cnt,
`endif
  output logic                           dbg_state,
  output logic [IDX_W-1:0]               dbg_rr_ptr,
  output logic [BC_W-1:0]                dbg_burst_cnt
);

  typedef enum logic {IDLE = 1'b0, OWN = 1'b1} state_t;

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [BC_W-1:0]      burst_cnt_q, burst_cnt_d;

  logic [IDX_W-1:0]     owner_idx;
  logic [IDX_W-1:0]     next_owner;
  logic [IDX_W-1:0]     start_idx;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_found;
  logic                 owner_req;
  logic                 xfer;
  logic                 stall;
  logic                 release_own;
  int                   srch_idx;

  // Handshake: req[i] is valid, gnt[i] & !w_full is ready; a word moves when both are high.
  assign owner_req = |(gnt_q & req);
  assign xfer      = owner_req & ~w_full;
  assign stall     = owner_req & w_full;

  assign gnt           = gnt_q;
  assign w_en          = xfer;
  assign busy          = |gnt_q;
  assign dbg_state     = state_q;
  assign dbg_rr_ptr    = rr_ptr_q;
  assign dbg_burst_cnt = burst_cnt_q;

  always_comb begin
    owner_idx = '0;
    w_data    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_q[i]) begin
        owner_idx = IDX_W'(i);
        w_data    = req_data[i*DATA_SIZE +: DATA_SIZE];
      end
    end
  end

  assign next_owner  = IDX_W'((int'(owner_idx) + 1) % NUM_REQ);
  assign start_idx   = (state_q == OWN) ? next_owner : rr_ptr_q;
  assign release_own = (state_q == OWN) &
                       (~owner_req | (xfer & (burst_cnt_q == BC_W'(MAX_BURST - 1))));

  // Cyclic first-set search; the owner itself is reached last, so it only wins as sole requester.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    srch_idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      srch_idx = (int'(start_idx) + k) % NUM_REQ;
      if (!pick_found && req[srch_idx]) begin
        pick_found = 1'b1;
        pick_idx   = IDX_W'(srch_idx);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          gnt_d       = NUM_REQ'(1) << pick_idx;
          burst_cnt_d = '0;
          state_d     = OWN;
        end
      end
      OWN: begin
        if (release_own) begin
          rr_ptr_d    = next_owner;
          burst_cnt_d = '0;
          if (pick_found) begin
            gnt_d   = NUM_REQ'(1) << pick_idx;
            state_d = OWN;
          end else begin
            gnt_d   = '0;
            state_d = IDLE;
          end
        end else if (xfer) begin
          burst_cnt_d = burst_cnt_q + BC_W'(1);
        end
      end
      default: begin
        state_d     = IDLE;
        gnt_d       = '0;
        burst_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge w_clk) begin
    if (!wrst_n) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

`ifdef WR_ARB_STATS_EN
  logic [CNT_SIZE-1:0] xfer_cnt_q, xfer_cnt_d;
  logic [CNT_SIZE-1:0] stall_cnt_q, stall_cnt_d;

  // Saturating counters: they stop at all-ones rather than wrapping.
  always_comb begin
    xfer_cnt_d  = xfer_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (xfer && !(&xfer_cnt_q))
      xfer_cnt_d = xfer_cnt_q + CNT_SIZE'(1);
    if (stall && !(&stall_cnt_q))
      stall_cnt_d = stall_cnt_q + CNT_SIZE'(1);
  end

  always_ff @(posedge w_clk) begin
    if (!wrst_n) begin
      xfer_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      xfer_cnt_q  <= xfer_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign xfer_cnt  = xfer_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (default parameters: 4 requesters, 8-bit data, bursts of 4).
// Inputs change 1 ns after a rising edge; outputs are checked 1 ns later, well clear of the next edge.
module tb_fifo_wr_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int DATA_SIZE = 8;
  localparam int MAX_BURST = 4;
  localparam int CNT_SIZE  = 16;

  logic                         w_clk;
  logic                         wrst_n;
  logic [NUM_REQ-1:0]           req;
  logic [NUM_REQ*DATA_SIZE-1:0] req_data;
  logic                         w_full;
  logic [NUM_REQ-1:0]           gnt;
  logic                         w_en;
  logic [DATA_SIZE-1:0]         w_data;
  logic                         busy;
  logic                         dbg_state;
  logic [1:0]                   dbg_rr_ptr;
  logic [2:0]                   dbg_burst_cnt;
`ifdef WR_ARB_STATS_EN
  logic [CNT_SIZE-1:0]          xfer_cnt;
  logic [CNT_SIZE-1:0]          stall_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;

  fifo_wr_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_SIZE(DATA_SIZE), .MAX_BURST(MAX_BURST), .CNT_SIZE(CNT_SIZE)
  ) dut (
    .w_clk(w_clk), .wrst_n(wrst_n), .req(req), .req_data(req_data), .w_full(w_full),
    .gnt(gnt), .w_en(w_en), .w_data(w_data), .busy(busy),
`ifdef WR_ARB_STATS_EN
    .xfer_cnt(xfer_cnt), .stall_cnt(stall_cnt),
`endif
    .dbg_state(dbg_state), .dbg_rr_ptr(dbg_rr_ptr), .dbg_burst_cnt(dbg_burst_cnt)
  );

  // clock
  initial w_clk = 1'b0;
  always #5 w_clk = ~w_clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance past one rising edge; inputs set afterwards apply to the next edge.
  task automatic step();
    @(posedge w_clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    req_data = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    wrst_n   = 1'b0;
    req      = 4'b1111;
    w_full   = 1'b0;

    // 1. reset held two edges with every requester asking
    step();
    step();
    settle();
    check_eq("rst_gnt", gnt, 4'b0000);
    check_eq("rst_w_en", w_en, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_state", dbg_state, 1'b0);
    check_eq("rst_rr", dbg_rr_ptr, 2'd0);
    check_eq("rst_data", w_data, 8'h00);
    wrst_n = 1'b1;
    step();
    settle();
    check_eq("first_gnt", gnt, 4'b0001);
    check_eq("first_busy", busy, 1'b1);

    // 2. two requesters share in bursts of four with no bubble
    req = 4'b0101;
    settle();
    for (int k = 0; k < MAX_BURST; k++) begin
      check_eq("b0_gnt", gnt, 4'b0001);
      check_eq("b0_w_en", w_en, 1'b1);
      check_eq("b0_data", w_data, 8'hA0);
      step();
    end
    for (int k = 0; k < MAX_BURST; k++) begin
      check_eq("b2_gnt", gnt, 4'b0100);
      check_eq("b2_w_en", w_en, 1'b1);
      check_eq("b2_data", w_data, 8'hC2);
      step();
    end
    check_eq("back_to_0", gnt, 4'b0001);

    // 3. owner 0 drops, requester 1 takes over, then drops after two words
    req = 4'b0010;
    settle();
    check_eq("drop0_w_en", w_en, 1'b0);
    step();
    check_eq("r1_gnt", gnt, 4'b0010);
    check_eq("r1_data", w_data, 8'hB1);
    check_eq("r1_w_en_a", w_en, 1'b1);
    step();
    check_eq("r1_w_en_b", w_en, 1'b1);
    step();
    req = 4'b0000;
    settle();
    check_eq("r1_drop_w_en", w_en, 1'b0);
    step();
    check_eq("early_gnt", gnt, 4'b0000);
    check_eq("early_rr", dbg_rr_ptr, 2'd2);
    check_eq("early_busy", busy, 1'b0);
    check_eq("early_state", dbg_state, 1'b0);
    req = 4'b0011;
    settle();
    check_eq("idle_w_en", w_en, 1'b0);
    step();
    check_eq("wrap_gnt", gnt, 4'b0001);

    // 4. owner 2 stalls by w_full mid-burst
    req = 4'b0100;
    step();
    check_eq("s_gnt", gnt, 4'b0100);
    check_eq("s_w_en0", w_en, 1'b1);
    step();
    check_eq("s_bc1", dbg_burst_cnt, 3'd1);
    w_full = 1'b1;
    settle();
    for (int k = 0; k < 5; k++) begin
      check_eq("stall_w_en", w_en, 1'b0);
      check_eq("stall_gnt", gnt, 4'b0100);
      check_eq("stall_bc", dbg_burst_cnt, 3'd1);
      step();
    end
`ifdef WR_ARB_STATS_EN
    check_eq("stall_cnt5", stall_cnt, 16'd5);
`endif
    w_full = 1'b0;
    settle();
    for (int k = 0; k < 3; k++) begin
      check_eq("resume_w_en", w_en, 1'b1);
      check_eq("resume_gnt", gnt, 4'b0100);
      step();
    end
    check_eq("regrant_gnt", gnt, 4'b0100);
    check_eq("regrant_bc", dbg_burst_cnt, 3'd0);
    check_eq("regrant_rr", dbg_rr_ptr, 2'd3);
`ifdef WR_ARB_STATS_EN
    check_eq("xfer_cnt14", xfer_cnt, 16'd14);
`endif

    // 5. sole requester 3 streams without a bubble across re-grants
    req = 4'b1000;
    settle();
    check_eq("hand3_w_en", w_en, 1'b0);
    step();
    for (int k = 0; k < 9; k++) begin
      check_eq("solo_gnt", gnt, 4'b1000);
      check_eq("solo_w_en", w_en, 1'b1);
      check_eq("solo_data", w_data, 8'hD3);
      step();
    end
    check_eq("solo_bc", dbg_burst_cnt, 3'd1);
    check_eq("solo_rr", dbg_rr_ptr, 2'd0);
    check_eq("solo_gnt10", gnt, 4'b1000);
    check_eq("solo_w_en10", w_en, 1'b1);

    // 6. reset lands during requester 3's second word of a burst
    wrst_n = 1'b0;
    req    = 4'b1001;
    step();
    check_eq("mid_rst_gnt", gnt, 4'b0000);
    check_eq("mid_rst_w_en", w_en, 1'b0);
    check_eq("mid_rst_rr", dbg_rr_ptr, 2'd0);
    check_eq("mid_rst_bc", dbg_burst_cnt, 3'd0);
`ifdef WR_ARB_STATS_EN
    check_eq("mid_rst_xfer", xfer_cnt, 16'd0);
    check_eq("mid_rst_stall", stall_cnt, 16'd0);
`endif
    wrst_n = 1'b1;
    step();
    check_eq("post_rst_gnt", gnt, 4'b0001);
    check_eq("post_rst_data", w_data, 8'hA0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
